// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-update signal bundle for branch_resolve_queue.
// master = fetch/execute side, slave = the queue.
interface branch_resolve_queue_if #(
  parameter int PC_W = 32
);
  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] pred_pc;
  logic            res_valid;
  logic            res_taken;
  logic            upd_valid;
  logic            upd_taken;
  logic [PC_W-1:0] upd_pc;
  logic            mispredict;

  modport master (
    output pred_valid, pred_taken, pred_pc, res_valid, res_taken,
    input  upd_valid, upd_taken, upd_pc, mispredict
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, res_valid, res_taken,
    output upd_valid, upd_taken, upd_pc, mispredict
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time branch predictions; retires the oldest on resolve,
// drives the predictor update port, and flushes younger entries on a mispredict.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  branch_resolve_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            taken_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [CNT_W-1:0] branch_q, branch_d, miss_q, miss_d;
  logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic             mis_q, mis_d;

  logic is_full, is_empty, pop, miss, push;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign pop      = bus.res_valid && !is_empty;
  assign miss     = pop && (taken_mem[head_q] != bus.res_taken);
  // A flushing pop discards the same-cycle enqueue; a plain pop frees a full slot.
  assign push     = bus.pred_valid && (!is_full || pop) && !miss;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ovf_d       = ovf_q | (bus.pred_valid && is_full && !pop);
    unf_d       = unf_q | (bus.res_valid && is_empty);
    branch_d    = branch_q;
    miss_d      = miss_q;
    upd_valid_d = pop;
    upd_taken_d = pop && bus.res_taken;
    upd_pc_d    = pop ? pc_mem[head_q] : '0;
    mis_d       = miss;
    if (miss) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop);
      tail_d  = tail_q + AW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (pop && branch_q != '1) branch_d = branch_q + CNT_W'(1);
    if (miss && miss_q != '1)  miss_d   = miss_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      branch_q    <= '0;
      miss_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_pc_q    <= '0;
      mis_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      branch_q    <= branch_d;
      miss_q      <= miss_d;
      upd_valid_q <= upd_valid_d;
      upd_taken_q <= upd_taken_d;
      upd_pc_q    <= upd_pc_d;
      mis_q       <= mis_d;
    end
  end

  // Payload storage needs no reset: occupancy gates every read.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      taken_mem[tail_q] <= bus.pred_taken;
      pc_mem[tail_q]    <= bus.pred_pc;
    end
  end

  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_taken  = upd_taken_q;
  assign bus.upd_pc     = upd_pc_q;
  assign bus.mispredict = mis_q;
  assign count          = count_q;
  assign full           = is_full;
  assign empty          = is_empty;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;
  assign branch_cnt     = branch_q;
  assign miss_cnt       = miss_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a random
// run, all checked against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clock = 1'b0;
  logic reset;
  logic [3:0]       count;
  logic             full, empty, overflow, underflow;
  logic [CNT_W-1:0] branch_cnt, miss_cnt;

  branch_resolve_queue_if #(.PC_W(PC_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  typedef struct { bit t; logic [PC_W-1:0] pc; } ent_t;
  ent_t q[$];
  bit               e_uv, e_ut, e_mis, e_ovf, e_unf;
  logic [PC_W-1:0]  e_upc;
  logic [CNT_W-1:0] e_bc, e_mc;
  int tests_run = 0;
  int tests_failed = 0;

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.pred_valid = 0; bus.pred_taken = 0; bus.pred_pc = '0;
    bus.res_valid = 0; bus.res_taken = 0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    e_uv = 0; e_ut = 0; e_upc = '0; e_mis = 0; e_ovf = 0; e_unf = 0; e_bc = '0; e_mc = '0;
  endtask

  // Drive one cycle of inputs, advance the model, step past the edge.
  task automatic cycle(input bit pv, input bit pt, input logic [PC_W-1:0] pc,
                       input bit rv, input bit rt);
    bit pop, miss, was_full;
    bus.pred_valid = pv; bus.pred_taken = pt; bus.pred_pc = pc;
    bus.res_valid = rv; bus.res_taken = rt;
    was_full = (q.size() == DEPTH);
    pop  = rv && (q.size() != 0);
    miss = pop && (q[0].t != rt);
    e_uv  = pop;
    e_ut  = pop && rt;
    e_upc = pop ? q[0].pc : '0;
    e_mis = miss;
    if (rv && !pop) e_unf = 1;
    if (pv && was_full && !pop) e_ovf = 1;
    if (pop && e_bc != CMAX) e_bc = e_bc + 1'b1;
    if (miss && e_mc != CMAX) e_mc = e_mc + 1'b1;
    if (pop) void'(q.pop_front());
    if (miss) q.delete();
    else if (pv && (!was_full || pop)) q.push_back('{pt, pc});
    @(posedge clock);
    #1;
    bus.pred_valid = 0; bus.res_valid = 0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({count, empty, full, bus.upd_valid, bus.mispredict, overflow, underflow, branch_cnt, miss_cnt}
        !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
      tests_failed++;
      $display("FAIL reset_initial: count=%0d empty=%b upd_valid=%b bc=%0d ovf=%b unf=%b, want 0/1/0/0/0/0",
               count, empty, bus.upd_valid, branch_cnt, overflow, underflow);
    end
    cycle(1, 1, 32'h10, 0, 0);
    cycle(1, 0, 32'h14, 1, 1);
    cycle(1, 1, 32'h18, 0, 0);
    cycle(1, 1, 32'h1c, 0, 0);
    tests_run++;
    if (count !== 4'd3) begin
      tests_failed++; $display("FAIL reset_prefill_count: got %0d want 3", count);
    end
    do_reset(2);
    tests_run++;
    if ({count, empty, bus.upd_valid, branch_cnt, overflow, underflow}
        !== {4'd0, 1'b1, 1'b0, {CNT_W{1'b0}}, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_midrun: count=%0d empty=%b upd_valid=%b bc=%0d ovf=%b unf=%b, want 0/1/0/0/0/0",
               count, empty, bus.upd_valid, branch_cnt, overflow, underflow);
    end
  endtask

  task automatic test_correct();
    logic [PC_W-1:0] pcs [3];
    bit              tk  [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    tk[0] = 1; tk[1] = 0; tk[2] = 1;
    do_reset(1);
    for (int i = 0; i < 3; i++) cycle(1, tk[i], pcs[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, '0, 1, tk[i]);
      tests_run++;
      if ({bus.upd_valid, bus.upd_taken, bus.upd_pc, bus.mispredict} !== {1'b1, tk[i], pcs[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL correct_upd%0d: valid=%b taken=%b pc=%h mis=%b, want 1/%b/%h/0",
                 i, bus.upd_valid, bus.upd_taken, bus.upd_pc, bus.mispredict, tk[i], pcs[i]);
      end
    end
    cycle(0, 0, '0, 0, 0);
    tests_run++;
    if ({bus.upd_valid, branch_cnt, miss_cnt, empty} !== {1'b0, CNT_W'(3), CNT_W'(0), 1'b1}) begin
      tests_failed++;
      $display("FAIL correct_counts: upd_valid=%b bc=%0d mc=%0d empty=%b, want 0/3/0/1",
               bus.upd_valid, branch_cnt, miss_cnt, empty);
    end
  endtask

  task automatic test_flush();
    do_reset(1);
    cycle(1, 1, 32'h180, 0, 0);
    cycle(1, 0, 32'h184, 0, 0);
    cycle(1, 1, 32'h188, 0, 0);
    cycle(1, 0, 32'h18c, 0, 0);
    cycle(1, 1, 32'h200, 1, 0);
    tests_run++;
    if ({bus.mispredict, bus.upd_valid, bus.upd_taken, bus.upd_pc, count, overflow, miss_cnt}
        !== {1'b1, 1'b1, 1'b0, 32'h180, 4'd0, 1'b0, CNT_W'(1)}) begin
      tests_failed++;
      $display("FAIL flush: mis=%b uv=%b ut=%b pc=%h count=%0d ovf=%b mc=%0d, want 1/1/0/180/0/0/1",
               bus.mispredict, bus.upd_valid, bus.upd_taken, bus.upd_pc, count, overflow, miss_cnt);
    end
    cycle(0, 0, '0, 1, 1);
    tests_run++;
    if ({underflow, bus.upd_valid, bus.mispredict, branch_cnt} !== {1'b1, 1'b0, 1'b0, CNT_W'(1)}) begin
      tests_failed++;
      $display("FAIL flush_then_resolve: unf=%b uv=%b mis=%b bc=%0d, want 1/0/0/1",
               underflow, bus.upd_valid, bus.mispredict, branch_cnt);
    end
  endtask

  task automatic test_full();
    logic [PC_W-1:0] want;
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 32'h300 + 32'(4 * i), 0, 0);
    tests_run++;
    if ({full, count} !== {1'b1, 4'd8}) begin
      tests_failed++; $display("FAIL full_fill: full=%b count=%0d, want 1/8", full, count);
    end
    cycle(1, 1, 32'h400, 0, 0);
    tests_run++;
    if ({overflow, count} !== {1'b1, 4'd8}) begin
      tests_failed++; $display("FAIL full_overflow: ovf=%b count=%0d, want 1/8", overflow, count);
    end
    cycle(1, 1, 32'h500, 1, 1);
    tests_run++;
    if ({count, bus.upd_pc, bus.mispredict} !== {4'd8, 32'h300, 1'b0}) begin
      tests_failed++;
      $display("FAIL full_push_pop: count=%0d pc=%h mis=%b, want 8/300/0", count, bus.upd_pc, bus.mispredict);
    end
    for (int i = 0; i < DEPTH; i++) begin
      want = (i == DEPTH - 1) ? 32'h500 : 32'h304 + 32'(4 * i);
      cycle(0, 0, '0, 1, 1);
      tests_run++;
      if ({bus.upd_valid, bus.upd_pc} !== {1'b1, want}) begin
        tests_failed++;
        $display("FAIL full_drain%0d: uv=%b pc=%h, want 1/%h", i, bus.upd_valid, bus.upd_pc, want);
      end
    end
    tests_run++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      tests_failed++; $display("FAIL full_drained: empty=%b count=%0d, want 1/0", empty, count);
    end
  endtask

  task automatic test_underflow();
    do_reset(1);
    cycle(1, 0, 32'h600, 1, 0);
    tests_run++;
    if ({underflow, bus.upd_valid, bus.mispredict, count, branch_cnt}
        !== {1'b1, 1'b0, 1'b0, 4'd1, CNT_W'(0)}) begin
      tests_failed++;
      $display("FAIL underflow: unf=%b uv=%b mis=%b count=%0d bc=%0d, want 1/0/0/1/0",
               underflow, bus.upd_valid, bus.mispredict, count, branch_cnt);
    end
    cycle(0, 0, '0, 1, 0);
    tests_run++;
    if ({bus.upd_valid, bus.upd_pc, bus.mispredict} !== {1'b1, 32'h600, 1'b0}) begin
      tests_failed++;
      $display("FAIL underflow_entry_kept: uv=%b pc=%h mis=%b, want 1/600/0",
               bus.upd_valid, bus.upd_pc, bus.mispredict);
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 32'h700 + 32'(i), 0, 0);
      cycle(0, 0, '0, 1, 0);
    end
    tests_run++;
    if ({branch_cnt, miss_cnt} !== {CNT_W'(15), CNT_W'(15)}) begin
      tests_failed++;
      $display("FAIL saturation: bc=%0d mc=%0d, want 15/15", branch_cnt, miss_cnt);
    end
  endtask

  task automatic test_random();
    bit pv, pt, rv, rt;
    int errs;
    do_reset(1);
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 3) != 0);
      pt = $urandom_range(0, 1);
      rv = ($urandom_range(0, 2) == 0);
      rt = (q.size() != 0 && $urandom_range(0, 7) != 0) ? q[0].t : 1'($urandom_range(0, 1));
      cycle(pv, pt, $urandom, rv, rt);
      tests_run++;
      if ({bus.upd_valid, bus.upd_taken, bus.upd_pc, bus.mispredict, count, full, empty,
           overflow, underflow, branch_cnt, miss_cnt}
          !== {e_uv, e_ut, e_upc, e_mis, 4'(q.size()), q.size() == DEPTH, q.size() == 0,
               e_ovf, e_unf, e_bc, e_mc}) begin
        tests_failed++;
        if (errs < 10)
          $display("FAIL random_c%0d: uv=%b ut=%b pc=%h mis=%b cnt=%0d ovf=%b unf=%b bc=%0d mc=%0d; want %b %b %h %b %0d %b %b %0d %0d",
                   i, bus.upd_valid, bus.upd_taken, bus.upd_pc, bus.mispredict, count, overflow,
                   underflow, branch_cnt, miss_cnt, e_uv, e_ut, e_upc, e_mis, q.size(), e_ovf,
                   e_unf, e_bc, e_mc);
        errs++;
      end
    end
  endtask

  initial begin
    do_reset(2);
    test_reset();
    test_correct();
    test_flush();
    test_full();
    test_underflow();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
